aes_inv_cipher: RTL

//   AES-128 inverse cipher (FIPS-197 sec 5.3). Decrypts one 128-bit block per request.

---
 rtl/aes_pkg.sv | 75 +++++++
 rtl/aes_inv_round.sv | 35 +++
 rtl/aes_inv_cipher.sv | 107 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box tables, Rcon, GF(2^8) helpers and FSM state encodings.
// Used by both the encryptor and the inverse cipher.
package aes_pkg;

  localparam int NR = 10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_KEYEXP = 3'd1;
  localparam logic [2:0] ST_INIT   = 3'd2;
  localparam logic [2:0] ST_ROUND  = 3'd3;
  localparam logic [2:0] ST_FINAL  = 3'd4;

  // Byte 0x00 sits in the top byte so the table reads in natural order.
  localparam logic [2047:0] SBOX_TBL = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
    256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
    256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
    256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
    256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
    256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
    256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
    256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant using an xtime chain; enough for 09/0b/0d/0e.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[0]}} & a) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless bypass_mix is set for the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         bypass_mix,
  output logic [127:0] state_out
);

  logic [127:0] added;
  logic [127:0] mixed;

  // Byte i is row i%4, column i/4; row r rotates right by r columns.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int SRC = (i % 4) + 4 * (((i / 4) + 4 - (i % 4)) % 4);
    assign added[127-8*i -: 8] = inv_sbox(state_in[127-8*SRC -: 8]) ^ round_key[127-8*i -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = added[127-32*c -: 8];
    assign a1 = added[119-32*c -: 8];
    assign a2 = added[111-32*c -: 8];
    assign a3 = added[103-32*c -: 8];
    assign mixed[127-32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
    assign mixed[119-32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
    assign mixed[111-32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
    assign mixed[103-32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
  end

  assign state_out = bypass_mix ? added : mixed;

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock, with on-chip key expansion
// and an optional cache of the expanded round keys.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid,
  output logic         AES_busy
);

  logic [2:0]   state_q;
  logic [3:0]   cnt_q;
  logic [127:0] s_q;
  logic [127:0] rk_q [0:NR];
  logic         rk_valid_q;

  logic [127:0] rk_prev;
  logic [31:0]  temp_w, nw0, nw1, nw2, nw3;
  logic [127:0] round_key, round_out;
  logic         bypass_mix, cache_hit;

  assign cache_hit = KEY_CACHE && rk_valid_q && (AES_key_in == rk_q[0]);

  // During KEYEXP cnt_q names the round key being produced.
  assign rk_prev = rk_q[cnt_q - 4'd1];
  assign temp_w  = {sbox(rk_prev[23:16]), sbox(rk_prev[15:8]),
                    sbox(rk_prev[7:0]),   sbox(rk_prev[31:24])} ^ {rcon(cnt_q), 24'h0};
  assign nw0 = rk_prev[127:96] ^ temp_w;
  assign nw1 = rk_prev[95:64]  ^ nw0;
  assign nw2 = rk_prev[63:32]  ^ nw1;
  assign nw3 = rk_prev[31:0]   ^ nw2;

  assign bypass_mix = (state_q == ST_FINAL);
  assign round_key  = bypass_mix ? rk_q[0] : rk_q[cnt_q];

  aes_inv_round u_round (
    .state_in   (s_q),
    .round_key  (round_key),
    .bypass_mix (bypass_mix),
    .state_out  (round_out)
  );

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q            <= ST_IDLE;
      cnt_q              <= 4'd0;
      s_q                <= '0;
      rk_valid_q         <= 1'b0;
      AES_data_out       <= '0;
      AES_data_out_valid <= 1'b0;
      AES_busy           <= 1'b0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      AES_data_out_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (AES_en) begin
            s_q      <= AES_data_in;
            rk_q[0]  <= AES_key_in;
            AES_busy <= 1'b1;
            if (cache_hit) begin
              state_q <= ST_INIT;
            end else begin
              rk_valid_q <= 1'b0;
              cnt_q      <= 4'd1;
              state_q    <= ST_KEYEXP;
            end
          end
        end
        ST_KEYEXP: begin
          rk_q[cnt_q] <= {nw0, nw1, nw2, nw3};
          if (cnt_q == 4'(NR)) begin
            rk_valid_q <= 1'b1;
            state_q    <= ST_INIT;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_INIT: begin
          s_q     <= s_q ^ rk_q[NR];
          cnt_q   <= 4'd9;
          state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          s_q <= round_out;
          if (cnt_q == 4'd1) state_q <= ST_FINAL;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ST_FINAL: begin
          AES_data_out       <= round_out;
          AES_data_out_valid <= 1'b1;
          AES_busy           <= 1'b0;
          state_q            <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
